// File: rtl/fir_event_detector.sv
// fir_event_detector: debounces a 1-bit detect stream with on/off hysteresis and
// queues {start timestamp, width} records of each qualified pulse in a small FIFO.
module fir_event_detector #(
   parameter int ON_CNT  = 3,
   parameter int OFF_CNT = 3,
   parameter int TS_W    = 16,
   parameter int WID_W   = 8,
   parameter int DEPTH   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   output logic             det,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [TS_W-1:0]  ev_start,
   output logic [WID_W-1:0] ev_width,
   output logic [15:0]      ev_count,
   output logic             ovf,
   input  logic             ovf_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [15:0] ON_N  = 16'(ON_CNT);
   localparam logic [15:0] OFF_N = 16'(OFF_CNT);
   localparam logic [31:0] WMAX  = (32'd1 << WID_W) - 32'd1;
   typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, RELEASING} state_t;
   state_t st;
   logic [TS_W-1:0] ts, cand;
   logic [WID_W-1:0] width;
   logic [15:0] run, zrun;
   logic [TS_W+WID_W-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic push, wr, pop, full, empty;

   function automatic logic [WID_W-1:0] sat_add(input logic [WID_W-1:0] a, input logic [15:0] b);
      logic [31:0] s;
      s = 32'(a) + 32'(b);
      return (s > WMAX) ? WID_W'(WMAX) : WID_W'(s);
   endfunction

   assign empty = wp == rp;
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign pop = !empty && ev_ready;
   // the event ends on the sample that completes the run of OFF_CNT zeros
   assign push = !din && ((st == ACTIVE && OFF_N == 16'd1) || (st == RELEASING && zrun + 16'd1 == OFF_N));
   assign wr = push && (!full || pop);
   assign ev_valid = !empty;
   assign {ev_start, ev_width} = empty ? '0 : mem[rp[AW-1:0]];

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st    <= IDLE;
         det   <= 1'b0;
         ts    <= '0;
         cand  <= '0;
         width <= '0;
         run   <= '0;
         zrun  <= '0;
      end else begin
         ts <= ts + TS_W'(1);
         case (st)
            IDLE:
               if (din) begin
                  cand  <= ts;
                  width <= WID_W'(1);
                  run   <= 16'd1;
                  st    <= (ON_N == 16'd1) ? ACTIVE : ARMING;
                  det   <= ON_N == 16'd1;
               end
            ARMING:
               if (din) begin
                  run   <= run + 16'd1;
                  width <= sat_add(width, 16'd1);
                  if (run + 16'd1 == ON_N) begin
                     st  <= ACTIVE;
                     det <= 1'b1;
                  end
               end else
                  st <= IDLE;
            ACTIVE:
               if (din)
                  width <= sat_add(width, 16'd1);
               else if (push) begin
                  st  <= IDLE;
                  det <= 1'b0;
               end else begin
                  st   <= RELEASING;
                  zrun <= 16'd1;
               end
            RELEASING:
               if (din) begin
                  width <= sat_add(width, zrun + 16'd1);
                  st    <= ACTIVE;
               end else if (push) begin
                  st  <= IDLE;
                  det <= 1'b0;
               end else
                  zrun <= zrun + 16'd1;
            default: st <= IDLE;
         endcase
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp       <= '0;
         rp       <= '0;
         ev_count <= '0;
         ovf      <= 1'b0;
      end else begin
         if (wr) wp <= wp + (AW+1)'(1);
         if (pop) rp <= rp + (AW+1)'(1);
         if (push) ev_count <= ev_count + 16'd1;
         ovf <= (push && !wr) || (ovf && !ovf_clr);
      end

   always_ff @(posedge clk)
      if (wr) mem[wp[AW-1:0]] <= {cand, width};
endmodule

// File: tb/tb_fir_event_detector.sv
// tb_fir_event_detector: directed test-plan scenarios plus random traffic, all
// compared against a sample-history reference model of pulses and the event queue.
module tb_fir_event_detector;
   logic clk = 0, rst = 1, din = 0, ev_ready = 1, ovf_clr = 0;
   logic det, ev_valid, ovf;
   logic [15:0] ev_start, ev_count;
   logic [7:0] ev_width;
   int checks = 0, errors = 0;

   fir_event_detector dut (
      .clk(clk), .rst(rst), .din(din), .det(det), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_start(ev_start), .ev_width(ev_width), .ev_count(ev_count), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   // reference model: pulses described by start/last-one sample index
   typedef struct {int s; int w;} rec_t;
   rec_t q[$];
   int n, ones, zeros, start, last;
   bit active, m_ovf;
   logic [15:0] m_count;

   task automatic model_reset();
      n = 0; ones = 0; zeros = 0; active = 0; m_ovf = 0; m_count = 0;
      q.delete();
   endtask

   task automatic model_edge(input bit d, input bit rdy, input bit clr);
      bit ev;
      rec_t r;
      ev = 0;
      if (!active) begin
         if (d) begin
            ones++;
            if (ones == 1) start = n;
            if (ones == 3) begin active = 1; last = n; zeros = 0; end
         end else ones = 0;
      end else if (d) begin
         last = n; zeros = 0;
      end else begin
         zeros++;
         if (zeros == 3) begin ev = 1; active = 0; ones = 0; end
      end
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (clr) m_ovf = 0;
      if (ev) begin
         r.s = start % 65536;
         r.w = (last - start + 1 > 255) ? 255 : last - start + 1;
         m_count++;
         if (q.size() < 4) q.push_back(r); else m_ovf = 1;
      end
      n++;
   endtask

   function automatic int exp_start(); return q.size() > 0 ? q[0].s : 0; endfunction
   function automatic int exp_width(); return q.size() > 0 ? q[0].w : 0; endfunction

   task automatic cyc(input bit d, input bit rdy, input bit clr);
      din = d; ev_ready = rdy; ovf_clr = clr;
      @(posedge clk);
      model_edge(d, rdy, clr);
      #1;
   endtask

   task automatic do_reset();
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      din = 0; ev_ready = 1; ovf_clr = 0;
      model_reset();
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      checks++;
      if ({det, ev_valid, ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {det, ev_valid, ovf}); end
      checks++;
      if (ev_start !== 0 || ev_width !== 0 || ev_count !== 0) begin
         errors++; $display("FAIL reset_fields: got start=%0d width=%0d count=%0d expected 0", ev_start, ev_width, ev_count);
      end
      rst = 0;
      model_reset();
   endtask

   task automatic test_glitch();
      do_reset();
      for (int t = 0; t < 16; t++) begin
         cyc(t == 5 || t == 6, 1, 0);
         checks++;
         if (det !== 0 || ev_valid !== 0) begin errors++; $display("FAIL glitch t=%0d: got det=%b valid=%b expected 0 0", t, det, ev_valid); end
      end
      checks++;
      if (ev_count !== 0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", ev_count); end
   endtask

   task automatic test_clean_pulse();
      do_reset();
      for (int t = 0; t < 26; t++) begin
         cyc(t >= 10 && t <= 17, 1, 0);
         if (t == 11 || t == 12 || t == 19 || t == 20) begin
            checks++;
            if (det !== (t == 12 || t == 19)) begin errors++; $display("FAIL clean_det t=%0d: got %b expected %b", t, det, t == 12 || t == 19); end
         end
         if (t == 20) begin
            checks++;
            if (ev_valid !== 1 || ev_start !== 10 || ev_width !== 8 || ev_count !== 1) begin
               errors++; $display("FAIL clean_rec: got valid=%b start=%0d width=%0d count=%0d expected 1 10 8 1", ev_valid, ev_start, ev_width, ev_count);
            end
         end
      end
      checks++;
      if (ev_valid !== 0) begin errors++; $display("FAIL clean_drain: got valid=%b expected 0", ev_valid); end
   endtask

   task automatic test_gap_bridging();
      do_reset();
      for (int t = 0; t < 50; t++) begin
         cyc((t >= 30 && t < 35) || (t >= 37 && t < 41), 1, 0);
         if (t == 36) begin
            checks++;
            if (det !== 1) begin errors++; $display("FAIL gap_det: got %b expected 1", det); end
         end
         if (t == 43) begin
            checks++;
            if (ev_valid !== 1 || ev_start !== 30 || ev_width !== 11) begin
               errors++; $display("FAIL gap_rec: got valid=%b start=%0d width=%0d expected 1 30 11", ev_valid, ev_start, ev_width);
            end
         end
      end
      checks++;
      if (ev_count !== 1) begin errors++; $display("FAIL gap_count: got %0d expected 1", ev_count); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int t = 0; t < 520; t++) cyc(t >= 100 && (t % 100) < 8, 0, 0);
      checks++;
      if (ev_valid !== 1 || ovf !== 1 || ev_count !== 5 || ev_start !== 100) begin
         errors++; $display("FAIL ovf_state: got valid=%b ovf=%b count=%0d start=%0d expected 1 1 5 100", ev_valid, ovf, ev_count, ev_start);
      end
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (ev_valid !== 1 || ev_start !== 16'(100 * k)) begin errors++; $display("FAIL ovf_pop%0d: got valid=%b start=%0d expected 1 %0d", k, ev_valid, ev_start, 100 * k); end
         cyc(0, 1, 0);
      end
      checks++;
      if (ev_valid !== 0) begin errors++; $display("FAIL ovf_empty: got valid=%b expected 0", ev_valid); end
      cyc(0, 0, 1);
      checks++;
      if (ovf !== 0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int t = 0; t < 520; t++) cyc(t >= 100 && (t % 100) < 8, t == 510, 0);
      checks++;
      if (ovf !== 0 || ev_count !== 5 || ev_start !== 200) begin
         errors++; $display("FAIL collide_state: got ovf=%b count=%0d start=%0d expected 0 5 200", ovf, ev_count, ev_start);
      end
      for (int k = 2; k <= 5; k++) begin
         checks++;
         if (ev_valid !== 1 || ev_start !== 16'(100 * k)) begin errors++; $display("FAIL collide_pop%0d: got valid=%b start=%0d expected 1 %0d", k, ev_valid, ev_start, 100 * k); end
         cyc(0, 1, 0);
      end
      checks++;
      if (ev_valid !== 0) begin errors++; $display("FAIL collide_empty: got valid=%b expected 0", ev_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int t = 0; t < 56; t++) cyc((t % 20) >= 10 && (t % 20) < 18, 0, 0);
      checks++;
      if (det !== 1 || ev_count !== 2 || ev_valid !== 1) begin errors++; $display("FAIL mid_pre: got det=%b count=%0d valid=%b expected 1 2 1", det, ev_count, ev_valid); end
      rst = 1;
      #1;
      checks++;
      if (det !== 0 || ev_valid !== 0 || ev_count !== 0 || ovf !== 0) begin
         errors++; $display("FAIL mid_rst: got det=%b valid=%b count=%0d ovf=%b expected 0 0 0 0", det, ev_valid, ev_count, ovf);
      end
      @(posedge clk);
      #1 rst = 0;
      model_reset();
      for (int t = 0; t < 14; t++) cyc(t >= 3 && t <= 10, 1, 0);
      checks++;
      if (ev_valid !== 1 || ev_start !== 3 || ev_width !== 8) begin
         errors++; $display("FAIL mid_restart: got valid=%b start=%0d width=%0d expected 1 3 8", ev_valid, ev_start, ev_width);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int t = 0; t < 308; t++) cyc(t >= 5 && t < 305, 1, 0);
      checks++;
      if (ev_valid !== 1 || ev_start !== 5 || ev_width !== 255) begin
         errors++; $display("FAIL saturate: got valid=%b start=%0d width=%0d expected 1 5 255", ev_valid, ev_start, ev_width);
      end
   endtask

   task automatic test_random();
      bit d, rdy, clr;
      do_reset();
      d = 0;
      for (int t = 0; t < 4000; t++) begin
         if ($urandom_range(0, 3) == 0) d = !d;
         rdy = $urandom_range(0, 9) < 2;
         clr = $urandom_range(0, 49) == 0;
         cyc(d, rdy, clr);
         checks++;
         if (det !== active || ev_valid !== (q.size() > 0) || ovf !== m_ovf || ev_count !== m_count
             || ev_start !== 16'(exp_start()) || ev_width !== 8'(exp_width())) begin
            errors++;
            $display("FAIL random t=%0d: got det=%b valid=%b ovf=%b count=%0d start=%0d width=%0d expected %b %b %b %0d %0d %0d",
                     t, det, ev_valid, ovf, ev_count, ev_start, ev_width, active, q.size() > 0, m_ovf, m_count, exp_start(), exp_width());
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_clean_pulse();
      test_gap_bridging();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fir_event_detector.md
# fir_event_detector

Downstream consumer of the fir9 threshold output. Debounces the 1-bit detect stream with on/off hysteresis, timestamps each qualified pulse, measures its width, and queues {start, width} records in a small FIFO drained over a valid/ready interface. It sits directly after fir9 and converts a per-sample decision bit into discrete event records for logging or a host.

## Interface
Parameters:
- ON_CNT, 3, consecutive 1 samples required to declare a pulse (≥1)
- OFF_CNT, 3, consecutive 0 samples required to end a pulse (≥1)
- TS_W, 16, timestamp width
- WID_W, 8, pulse width field width
- DEPTH, 4, event FIFO depth (power of 2)

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  1  fir9 threshold output `y`; sampled every edge
- det  out  1  debounced pulse level
- ev_valid  out  1  FIFO head record available
- ev_ready  in  1  consumer accepts head record
- ev_start  out  TS_W  timestamp of the first 1 sample of the head event
- ev_width  out  WID_W  width of the head event in samples, saturating
- ev_count  out  16  completed events, including dropped ones; wraps
- ovf  out  1  sticky: a record was dropped because the FIFO was full
- ovf_clr  in  1  synchronous clear of ovf

## Operation
- Timestamp ts: reset 0; +1 every edge; wraps at 2^TS_W. A sample taken at an edge is tagged with ts before that edge increments it.
- FSM states:
  - IDLE (det=0): din=1 → ARMING with run=1, cand=ts, width=1. If ON_CNT=1, go straight to ACTIVE.
  - ARMING (det=0): din=1 → run+1, width+1. When run reaches ON_CNT → ACTIVE, det=1. din=0 → IDLE; the glitch is discarded and no record is written.
  - ACTIVE (det=1): din=1 → width+1. din=0 → RELEASING with zrun=1. If OFF_CNT=1, end the event immediately.
  - RELEASING (det=1): din=0 → zrun+1; when zrun reaches OFF_CNT, end the event. din=1 → ACTIVE with width += zrun+1, so the gap is bridged.
- End event: push {cand, width} into the FIFO, ev_count+1, det=0, → IDLE.
- Width is the number of samples from the first 1 to the last 1 of the pulse, inclusive. It saturates at 2^WID_W−1.
- FIFO behaviour:
  - ev_valid = not empty. ev_start/ev_width show the head record combinationally from FIFO storage.
  - A pop occurs at an edge where ev_valid && ev_ready.
  - ev_ready while empty is ignored.
- Full FIFO handling:
  - Push while full with no pop in the same edge: record dropped, ovf←1, ev_count still increments.
  - Push and pop in the same edge while full: both succeed, no overflow.
- ovf_clr clears ovf. If an overflow occurs in the same edge, ovf stays 1.
- Reset values: det=0, ev_valid=0, ev_start=0, ev_width=0, ev_count=0, ovf=0. FSM returns to IDLE, ts=0, FIFO empty.
- Reset mid-pulse discards the pulse in progress and all queued records.

## Timing
- det rises at the edge sampling the ON_CNT-th consecutive 1. If the first 1 is sampled at edge k, det is high after edge k+ON_CNT−1.
- det falls at the edge sampling the OFF_CNT-th consecutive 0. The push happens at that same edge.
- ev_valid rises 1 cycle after a push into an empty FIFO.
- Head record updates 1 cycle after a pop. ev_valid falls 1 cycle after popping the last record.
- Throughput: 1 push and 1 pop per cycle maximum.
- A minimum event spans ON_CNT+OFF_CNT samples, so pushes are never back-to-back.
- Pulses spanning a ts wrap are legal; ev_start keeps the pre-wrap value.

## Test plan
All scenarios use defaults; rst is released before the edge tagged ts=0; ev_ready=1 unless stated.
- Glitch rejection: din=1 at ts 5,6, then 0 → det stays 0, ev_valid stays 0, ev_count=0.
- Clean pulse: din=1 at ts 10..17, 0 thereafter →
  - det high after the ts=12 edge, low after the ts=20 edge.
  - ev_valid high the next cycle with ev_start=10, ev_width=8.
  - ev_count=1.
- Gap bridging: starting ts=30, din = 1×5, 0×2, 1×4, 0×3 → exactly one record: ev_start=30, ev_width=11.
- Backpressure and overflow: ev_ready=0, five clean pulses starting at ts 100, 200, 300, 400, 500 →
  - 4 records held, ovf=1, ev_count=5.
  - Raise ev_ready → starts 100, 200, 300, 400 pop in order; ev_valid then falls.
- Push/pop collision: FIFO full, ev_ready pulsed in the same edge as the 5th push → ovf stays 0, and the 5th record is retained at the tail.
- Reset mid-operation: assert rst while det=1 with 2 records queued → immediately det=0, ev_valid=0, ev_count=0, ovf=0; after release, ts restarts at 0.
